// File: rtl/pasabajas_biquad_param.sv
// pasabajas_biquad_param: runtime-programmable direct-form-I biquad using one shared multiplier
// Ports:
//   clk, rst (async active-low)      clock and reset
//   rx, u                            sample strobe and W-bit input sample
//   clr                              clear history and sticky flags (idle only)
//   coef_we, coef_addr, coef_data    coefficient write: 0=b0 1=b1 2=b2 3=a1 4=a2
//   rx_2, y                          done pulse and held filtered output
//   busy, sat, ovr                   in progress, sticky saturation, sticky dropped strobe
module pasabajas_biquad_param #(
  parameter int W  = 25,
  parameter int F  = 15,
  parameter int AW = 2*W+3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic [W-1:0] u,
  input  logic         clr,
  input  logic         coef_we,
  input  logic [2:0]   coef_addr,
  input  logic [W-1:0] coef_data,
  output logic         rx_2,
  output logic [W-1:0] y,
  output logic         busy,
  output logic         sat,
  output logic         ovr
);
  typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_t;
  localparam logic [W-1:0] ONE = W'(1) << F;
  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic signed [W-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [W-1:0] y1_q, y1_d, y2_q, y2_d, y_q, y_d, y_new_q, y_new_d;
  logic signed [W-1:0] coef_q [5];
  logic signed [W-1:0] coef_d [5];
  logic signed [AW-1:0] acc_q, acc_d;
  logic rx_2_q, rx_2_d, busy_q, busy_d, sat_q, sat_d, ovr_q, ovr_d;
  logic signed [W-1:0] c_k, o_k;
  logic [2*W-1:0] prod;
  logic signed [AW-1:0] prod_x, sh;
  logic fits;
  assign rx_2 = rx_2_q;
  assign y    = y_q;
  assign busy = busy_q;
  assign sat  = sat_q;
  assign ovr  = ovr_q;
  always_comb begin
    c_k = (k_q == 3'd0) ? coef_q[0] : (k_q == 3'd1) ? coef_q[1] : (k_q == 3'd2) ? coef_q[2] :
          (k_q == 3'd3) ? coef_q[3] : coef_q[4];
    o_k = (k_q == 3'd0) ? x0_q : (k_q == 3'd1) ? x1_q : (k_q == 3'd2) ? x2_q :
          (k_q == 3'd3) ? y1_q : y2_q;
    // both operands sign-extended to 2W so the low 2W bits are the exact signed product
    prod   = {{W{c_k[W-1]}}, c_k} * {{W{o_k[W-1]}}, o_k};
    prod_x = {{(AW-2*W){prod[2*W-1]}}, prod};
    sh     = acc_q >>> F;
    // result fits in W bits when everything above the W-bit sign position agrees
    fits   = (&sh[AW-1:W-1]) | ~(|sh[AW-1:W-1]);
    state_d = state_q;
    k_d     = k_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y_d     = y_q;
    y_new_d = y_new_q;
    acc_d   = acc_q;
    coef_d  = coef_q;
    rx_2_d  = 1'b0;
    busy_d  = busy_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          x1_d  = '0;
          x2_d  = '0;
          y1_d  = '0;
          y2_d  = '0;
          sat_d = 1'b0;
          ovr_d = 1'b0;
        end
        if (rx) begin
          x0_d    = u;
          acc_d   = '0;
          busy_d  = 1'b1;
          k_d     = 3'd0;
          state_d = MAC;
        end else if (coef_we) begin
          for (int i = 0; i < 5; i++)
            if (coef_addr == 3'(i)) coef_d[i] = coef_data;
        end
      end
      MAC: begin
        acc_d   = (k_q >= 3'd3) ? acc_q - prod_x : acc_q + prod_x;
        k_d     = k_q + 3'd1;
        state_d = (k_q == 3'd4) ? SAT : MAC;
      end
      SAT: begin
        y_new_d = fits ? sh[W-1:0] : sh[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        sat_d   = sat_q | ~fits;
        state_d = DONE;
      end
      default: begin
        y_d     = y_new_q;
        rx_2_d  = 1'b1;
        x2_d    = x1_q;
        x1_d    = x0_q;
        y2_d    = y1_q;
        y1_d    = y_new_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (rx && state_q != IDLE) ovr_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      y_q       <= '0;
      y_new_q   <= '0;
      acc_q     <= '0;
      coef_q[0] <= ONE;
      coef_q[1] <= '0;
      coef_q[2] <= '0;
      coef_q[3] <= '0;
      coef_q[4] <= '0;
      rx_2_q    <= 1'b0;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y_q     <= y_d;
      y_new_q <= y_new_d;
      acc_q   <= acc_d;
      coef_q  <= coef_d;
      rx_2_q  <= rx_2_d;
      busy_q  <= busy_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_pasabajas_biquad_param.sv
// tb_pasabajas_biquad_param: randomized and directed checks against an arithmetic biquad model
module tb_pasabajas_biquad_param;
  localparam int W = 25;
  localparam int F = 15;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (W-1));
  logic clk = 1'b0;
  logic rst, rx, clr, coef_we;
  logic [W-1:0] u, coef_data;
  logic [2:0] coef_addr;
  logic rx_2, busy, sat, ovr;
  logic [W-1:0] y;
  int checks = 0;
  int errors = 0;
  longint mc [5];
  longint mx1, mx2, my1, my2;
  logic msat;
  pasabajas_biquad_param dut (
    .clk(clk), .rst(rst), .rx(rx), .u(u), .clr(clr), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .rx_2(rx_2), .y(y),
    .busy(busy), .sat(sat), .ovr(ovr)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    mc[0] = longint'(1) << F;
    for (int i = 1; i < 5; i++) mc[i] = 0;
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; msat = 1'b0;
  endtask
  task automatic model_step(input longint uu, output longint ye);
    longint acc, d, q;
    acc = mc[0]*uu + mc[1]*mx1 + mc[2]*mx2 - mc[3]*my1 - mc[4]*my2;
    d = longint'(1) << F;
    q = acc / d;
    if (acc < 0 && acc % d != 0) q = q - 1;
    if (q > MAXV) begin q = MAXV; msat = 1'b1; end
    else if (q < MINV) begin q = MINV; msat = 1'b1; end
    mx2 = mx1; mx1 = uu; my2 = my1; my1 = q;
    ye = q;
  endtask
  task automatic write_coef(input logic [2:0] a, input longint v);
    coef_we = 1'b1; coef_addr = a; coef_data = W'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (a < 3'd5) mc[a] = v;
  endtask
  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; msat = 1'b0;
  endtask
  task automatic do_sample(input longint uu, input string nm);
    longint ye;
    int n, bc;
    bit seen;
    model_step(uu, ye);
    rx = 1'b1; u = W'(uu);
    @(posedge clk); #1;
    rx = 1'b0;
    bc = busy ? 1 : 0;
    seen = 0; n = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (rx_2) begin seen = 1; n = i; end
      else if (busy) bc++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no rx_2 within 20 clocks", nm);
    end else begin
      if (n != 7) begin errors++; $display("FAIL %s latency: got %0d required 7", nm, n); end
      checks++;
      if (bc != 7) begin errors++; $display("FAIL %s busy cycles: got %0d required 7", nm, bc); end
      checks++;
      if (longint'($signed(y)) !== ye) begin errors++; $display("FAIL %s y: got %0d required %0d", nm, $signed(y), ye); end
      checks++;
      if (sat !== msat) begin errors++; $display("FAIL %s sat: got %b required %b", nm, sat, msat); end
    end
  endtask
  task automatic test_reset();
    rst = 1'b0; rx = 1'b0; clr = 1'b0; coef_we = 1'b0; u = '0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (y !== '0) begin errors++; $display("FAIL reset y: got %0d required 0", y); end
    if (rx_2 !== 1'b0) begin errors++; $display("FAIL reset rx_2: got %b required 0", rx_2); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    if (sat !== 1'b0) begin errors++; $display("FAIL reset sat: got %b required 0", sat); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL reset ovr: got %b required 0", ovr); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_identity();
    do_sample(1000, "identity_1000");
    checks++;
    if (longint'($signed(y)) !== 1000) begin errors++; $display("FAIL identity literal: got %0d required 1000", $signed(y)); end
    do_sample(-3, "identity_m3");
    @(posedge clk); #1;
    checks++;
    if (rx_2 !== 1'b0) begin errors++; $display("FAIL rx_2 width: got %b required 0", rx_2); end
  endtask
  task automatic test_average();
    do_clear();
    write_coef(0, 1 << 14);
    write_coef(1, 1 << 14);
    do_sample(2000, "avg_2000");
    do_sample(4000, "avg_4000");
    do_sample(0, "avg_0");
  endtask
  task automatic test_iir();
    do_clear();
    write_coef(0, 1 << 15);
    write_coef(1, 0);
    write_coef(3, -(1 << 14));
    do_sample(1024, "iir_imp");
    for (int i = 0; i < 3; i++) do_sample(0, "iir_tail");
    do_clear();
    do_sample(0, "iir_after_clr");
  endtask
  task automatic test_trunc();
    do_clear();
    write_coef(0, 1 << 14);
    write_coef(3, 0);
    do_sample(-3, "trunc_m3");
  endtask
  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_clear();
      for (int a = 0; a < 3; a++) write_coef(3'(a), longint'($urandom_range(0, 65535)) - 32768);
      for (int a = 3; a < 5; a++) write_coef(3'(a), longint'($urandom_range(0, 32767)) - 16384);
      write_coef(3'd5, longint'($urandom_range(0, 65535)));
      for (int s = 0; s < 6; s++) do_sample(longint'($urandom_range(0, 2097151)) - 1048576, "random");
    end
  endtask
  task automatic test_back_to_back();
    do_clear();
    do_sample(1234, "b2b_a");
    do_sample(-777, "b2b_b");
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL b2b ovr: got %b required 0", ovr); end
  endtask
  task automatic test_ovr();
    longint ye, yv;
    int pulses;
    do_clear();
    write_coef(0, 1 << 15);
    write_coef(1, 1 << 14);
    model_step(500, ye);
    rx = 1'b1; u = W'(500);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rx = 1'b1; u = W'(9999); coef_we = 1'b1; coef_addr = 3'd0; coef_data = W'(1 << 13);
    @(posedge clk); #1;
    rx = 1'b0; coef_we = 1'b0;
    pulses = 0; yv = 0;
    for (int i = 4; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rx_2) begin pulses++; yv = longint'($signed(y)); end
    end
    checks += 3;
    if (pulses != 1) begin errors++; $display("FAIL ovr pulses: got %0d required 1", pulses); end
    if (yv !== ye) begin errors++; $display("FAIL ovr y: got %0d required %0d", yv, ye); end
    if (ovr !== 1'b1) begin errors++; $display("FAIL ovr flag: got %b required 1", ovr); end
    do_sample(100, "ovr_coef_unchanged");
    do_clear();
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL ovr clr: got %b required 0", ovr); end
    model_step(200, ye);
    rx = 1'b1; u = W'(200);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rx = 1'b1; u = W'(123);
    @(posedge clk); #1;
    rx = 1'b0;
    checks += 3;
    if (rx_2 !== 1'b1) begin errors++; $display("FAIL done_drop rx_2: got %b required 1", rx_2); end
    if (longint'($signed(y)) !== ye) begin errors++; $display("FAIL done_drop y: got %0d required %0d", $signed(y), ye); end
    if (ovr !== 1'b1) begin errors++; $display("FAIL done_drop ovr: got %b required 1", ovr); end
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (rx_2 || busy) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL done_drop started: got %0d active cycles required 0", pulses); end
  endtask
  task automatic test_sat();
    do_clear();
    write_coef(0, (longint'(1) << 24) - 1);
    write_coef(1, 0);
    do_sample(longint'(1) << 23, "sat_pos");
    do_sample(-(longint'(1) << 23), "sat_neg");
  endtask
  task automatic test_reset_mid();
    int pulses;
    write_coef(0, 1 << 14);
    rx = 1'b1; u = W'(1000);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    model_reset();
    checks += 5;
    if (y !== '0) begin errors++; $display("FAIL mid_reset y: got %0d required 0", y); end
    if (rx_2 !== 1'b0) begin errors++; $display("FAIL mid_reset rx_2: got %b required 0", rx_2); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy: got %b required 0", busy); end
    if (sat !== 1'b0) begin errors++; $display("FAIL mid_reset sat: got %b required 0", sat); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL mid_reset ovr: got %b required 0", ovr); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (rx_2) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL mid_reset pulse: got %0d required 0", pulses); end
    do_sample(777, "mid_reset_identity");
  endtask
  initial begin
    test_reset();
    test_identity();
    test_average();
    test_iir();
    test_trunc();
    test_random();
    test_back_to_back();
    test_ovr();
    test_sat();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
